biquad_mc: RTL and testbench
============================

Name: biquad_mc

Overview:
- Time-multiplexed, multi-channel direct-form-I biquad IIR with one shared signed MAC and per-channel coefficient banks and history.
- Computes y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] + a1·y[n-1] + a2·y[n-2] per channel, with signed two's-complement arithmetic, rounding and output saturation.
- Sits between a sample source and sink using valid/ready handshakes; coefficients load through a simple register port from the bus slave.

Parameters:
- DATAWIDTH, 16, sample width (signed).
- COEFWIDTH, 16, coefficient width (signed).
- COEF_FRAC, 14, fractional bits of coefficients (default Q2.14, range [-2,2)).
- NCH, 4, number of channels (≥1).
- GUARD, 4, accumulator guard bits; accumulator width AW = DATAWIDTH+COEFWIDTH+GUARD.
- CHW (localparam) = max(1, clog2(NCH)).

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_ch  in  CHW  channel of input sample.
- in_data  in  DATAWIDTH  signed input sample.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- out_ch  out  CHW  channel of result.
- out_data  out  DATAWIDTH  signed filtered sample.
- out_sat  out  1  result was saturated.
- coef_we  in  1  coefficient write strobe.
- coef_ch  in  CHW  coefficient channel select.
- coef_sel  in  3  0=a1, 1=a2, 2=b0, 3=b1, 4=b2; 5–7 reserved.
- coef_wdata  in  COEFWIDTH  write data.
- coef_rdata  out  COEFWIDTH  combinational readback of [coef_ch][coef_sel]; 0 for reserved or out-of-range.
- clr  in  1  clear history of channel clr_ch.
- clr_ch  in  CHW  channel to clear.

Behaviour:
- Reset (nreset=0, async): coefficients, history (x1, x2, y1, y2 for all channels), accumulator and outputs go to 0. in_ready=0 while reset is asserted and 1 in the first cycle after release. out_valid, out_sat, out_ch and out_data reset to 0. A reset mid-computation drops the sample.
- FSM states: IDLE, MAC, SAT, OUT.
  - IDLE: in_ready=1. On in_valid: latch in_ch, in_data and a snapshot of that channel's 5 coefficients and 4 history words. Clear acc. Go to MAC (cycle 0).
  - MAC: 5 cycles (1–5), tap order b0·x, b1·x1, b2·x2, a1·y1, a2·y2. acc += sign-extended full product. Then go to SAT.
  - SAT (cycle 6): r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC (arithmetic shift; ties round toward +inf). Clamp r to [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1]; out_sat=1 if clamped. Register out_data and out_ch. Write back the channel history: x2←x1, x1←x, y2←y1, y1←clamped y. Go to OUT.
  - OUT (cycle 7 onward): out_valid=1. out_data, out_ch and out_sat stay stable until out_ready. On the handshake: out_valid→0 next cycle, go to IDLE.
- Latency: input handshake to out_valid is 7 cycles. Minimum sample period is 8 cycles. in_ready=0 in every state except IDLE.
- Coefficient writes take effect on the next clock in any state. A sample already in flight uses its snapshot, so a write is seen from the next accepted sample.
- Writes with reserved coef_sel or coef_ch ≥ NCH are ignored.
- clr zeroes the 4 history words of clr_ch on the next clock. If clr_ch is the channel being written back in SAT in the same cycle, clear wins: history = 0. The in-flight result is still output.
- in_ch ≥ NCH: the sample is accepted and the result is output with data 0 and out_sat=0. History is not updated.
- The accumulator never wraps for |coef|<2 and GUARD≥3. This is not checked in hardware.

Decomposition:
- Package biquad_pkg holds:
  - coefficient index constants (A1=0, A2=1, B0=2, B1=3, B2=4);
  - FSM state enum;
  - a history-record typedef (x1, x2, y1, y2).
- One sub-module, biquad_mac, contains the signed multiply, accumulate, clear, and round/saturate stage (parameters DATAWIDTH, COEFWIDTH, COEF_FRAC, GUARD).
- The coefficient and history arrays plus the FSM stay in biquad_mc.

Test Plan (defaults):
- Passthrough: ch0 b0=0x4000 (1.0), others 0; in_data=1000 → out_data=1000, out_sat=0, out_valid 7 cycles after the handshake.
- Recursion: ch1 b0=0x4000, a1=0x2000 (0.5); inputs 16384, 0, 0 → outputs 16384, 8192, 4096.
- Saturation and rounding:
  - b0=0x7FFF; x=30000 → 32767, out_sat=1; x=-30000 → -32768, out_sat=1.
  - b0=0x2000; x=3 → 2; x=-3 → -1.
- Channel independence and clear:
  - Interleave a ch0 impulse 16384 with ch2 zeros (ch2 a1=0x2000) → ch2 outputs stay 0, ch0 behaves as the recursion case.
  - clr on ch0 after the first output → next ch0 output with x=0 is 0.
- Backpressure and coefficient write: hold out_ready=0 for 10 cycles → out_data stable, in_ready=0. Write b0 during MAC → the current result uses the old b0 and the next sample uses the new one.
- Reset mid-MAC: drop nreset at cycle 3 → out_valid=0, all coefficients and history read back 0, in_ready=1 after release.

Source files
------------

// File: rtl/biquad_pkg.sv
// Shared types and constants for the multi-channel biquad filter.
package biquad_pkg;

   // Coefficient bank slot indices (also the coef_sel encoding)
   localparam logic [2:0] A1 = 3'd0;
   localparam logic [2:0] A2 = 3'd1;
   localparam logic [2:0] B0 = 3'd2;
   localparam logic [2:0] B1 = 3'd3;
   localparam logic [2:0] B2 = 3'd4;

   localparam int unsigned NCOEF  = 5;
   // History words are stored at the sample width of the default build
   localparam int unsigned HIST_W = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_SAT,
      S_OUT
   } state_t;

   // Per-channel direct-form-I history
   typedef struct packed {
      logic signed [HIST_W-1:0] x1;
      logic signed [HIST_W-1:0] x2;
      logic signed [HIST_W-1:0] y1;
      logic signed [HIST_W-1:0] y2;
   } hist_t;

endpackage

// File: rtl/biquad_mac.sv
// Shared signed multiply-accumulate with round-half-up and output clamp.
module biquad_mac #(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned COEFWIDTH = 16,
   parameter int unsigned COEF_FRAC = 14,
   parameter int unsigned GUARD     = 4
) (
   input  logic                        clk,
   input  logic                        nreset,
   input  logic                        clear,
   input  logic                        acc_en,
   input  logic signed [COEFWIDTH-1:0] coef,
   input  logic signed [DATAWIDTH-1:0] data,
   output logic signed [DATAWIDTH-1:0] y_c,
   output logic                        sat_c
);

   localparam int unsigned PW = DATAWIDTH + COEFWIDTH;
   localparam int unsigned AW = PW + GUARD;

   localparam logic signed [AW-1:0] HALF = AW'(1) << (COEF_FRAC - 1);
   localparam logic signed [AW-1:0] YMAX = AW'((64'd1 << (DATAWIDTH - 1)) - 64'd1);
   localparam logic signed [AW-1:0] YMIN = ~YMAX;

   logic signed [PW-1:0] prod_c;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] rsum_c;
   logic signed [AW-1:0] rnd_c;

   // Full-precision signed product of the current tap
   assign prod_c = PW'(coef) * PW'(data);

   // Accumulator: cleared between samples, one tap per enabled cycle
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (acc_en) begin
         acc <= acc + AW'(prod_c);
      end
   end

   // Round to nearest (ties toward +inf), then clamp to the sample range
   always_comb begin
      rsum_c = acc + HALF;
      rnd_c  = rsum_c >>> COEF_FRAC;
      y_c    = rnd_c[DATAWIDTH-1:0];
      sat_c  = 1'b0;
      if (rnd_c > YMAX) begin
         y_c   = YMAX[DATAWIDTH-1:0];
         sat_c = 1'b1;
      end else if (rnd_c < YMIN) begin
         y_c   = YMIN[DATAWIDTH-1:0];
         sat_c = 1'b1;
      end
   end

endmodule

// File: rtl/biquad_mc.sv
// Time-multiplexed multi-channel direct-form-I biquad with one shared MAC.
module biquad_mc
   import biquad_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned COEFWIDTH = 16,
   parameter int unsigned COEF_FRAC = 14,
   parameter int unsigned NCH       = 4,
   parameter int unsigned GUARD     = 4,
   localparam int unsigned CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                        clk,
   input  logic                        nreset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [CHW-1:0]              in_ch,
   input  logic signed [DATAWIDTH-1:0] in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [CHW-1:0]              out_ch,
   output logic signed [DATAWIDTH-1:0] out_data,
   output logic                        out_sat,
   input  logic                        coef_we,
   input  logic [CHW-1:0]              coef_ch,
   input  logic [2:0]                  coef_sel,
   input  logic signed [COEFWIDTH-1:0] coef_wdata,
   output logic signed [COEFWIDTH-1:0] coef_rdata,
   input  logic                        clr,
   input  logic [CHW-1:0]              clr_ch
);

   localparam bit FULL_CH = (NCH == (1 << CHW));

   logic signed [COEFWIDTH-1:0] coef_mem [NCH][NCOEF];
   hist_t                       hist_mem [NCH];

   state_t                      state;
   logic [2:0]                  cnt;
   logic [CHW-1:0]              s_ch;
   logic                        s_ok;
   logic signed [DATAWIDTH-1:0] s_x;
   logic signed [COEFWIDTH-1:0] s_coef [NCOEF];
   hist_t                       s_hist;

   logic                        in_ok_c;
   logic                        coef_ok_c;
   logic                        clr_ok_c;
   logic                        sel_ok_c;
   logic signed [COEFWIDTH-1:0] tap_coef_c;
   logic signed [DATAWIDTH-1:0] tap_data_c;
   logic signed [DATAWIDTH-1:0] mac_y_c;
   logic                        mac_sat_c;

   // Channel range checks only exist when NCH is not a power of two
   if (FULL_CH) begin : g_full_ch
      assign in_ok_c   = 1'b1;
      assign coef_ok_c = 1'b1;
      assign clr_ok_c  = 1'b1;
   end else begin : g_part_ch
      assign in_ok_c   = (in_ch   < CHW'(NCH));
      assign coef_ok_c = (coef_ch < CHW'(NCH));
      assign clr_ok_c  = (clr_ch  < CHW'(NCH));
   end

   assign sel_ok_c   = (coef_sel < 3'(NCOEF));
   assign coef_rdata = (coef_ok_c && sel_ok_c) ? coef_mem[coef_ch][coef_sel] : '0;

   // Coefficient bank writes, visible from the next accepted sample
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         coef_mem <= '{default: '0};
      end else if (coef_we && coef_ok_c && sel_ok_c) begin
         coef_mem[coef_ch][coef_sel] <= coef_wdata;
      end
   end

   // History write-back after saturation; a same-cycle clear takes priority
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         hist_mem <= '{default: '0};
      end else begin
         if ((state == S_SAT) && s_ok) begin
            hist_mem[s_ch] <= '{x1: s_x, x2: s_hist.x1, y1: mac_y_c, y2: s_hist.y1};
         end
         if (clr && clr_ok_c) begin
            hist_mem[clr_ch] <= '0;
         end
      end
   end

   // Tap select: b0*x, b1*x1, b2*x2, a1*y1, a2*y2
   always_comb begin
      tap_coef_c = s_coef[B0];
      tap_data_c = s_x;
      case (cnt)
         3'd1: begin tap_coef_c = s_coef[B1]; tap_data_c = s_hist.x1; end
         3'd2: begin tap_coef_c = s_coef[B2]; tap_data_c = s_hist.x2; end
         3'd3: begin tap_coef_c = s_coef[A1]; tap_data_c = s_hist.y1; end
         3'd4: begin tap_coef_c = s_coef[A2]; tap_data_c = s_hist.y2; end
         default: ;
      endcase
   end

   biquad_mac #(
      .DATAWIDTH (DATAWIDTH),
      .COEFWIDTH (COEFWIDTH),
      .COEF_FRAC (COEF_FRAC),
      .GUARD     (GUARD)
   ) u_mac (
      .clk    (clk),
      .nreset (nreset),
      .clear  (state == S_IDLE),
      .acc_en (state == S_MAC),
      .coef   (tap_coef_c),
      .data   (tap_data_c),
      .y_c    (mac_y_c),
      .sat_c  (mac_sat_c)
   );

   // Sample sequencer: accept+snapshot, 5 MAC taps, saturate, hold output
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         s_ch      <= '0;
         s_ok      <= 1'b0;
         s_x       <= '0;
         s_coef    <= '{default: '0};
         s_hist    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  s_ch     <= in_ch;
                  s_ok     <= in_ok_c;
                  s_x      <= in_data;
                  s_coef   <= coef_mem[in_ch];
                  s_hist   <= hist_mem[in_ch];
                  cnt      <= '0;
                  state    <= S_MAC;
               end
            end
            S_MAC: begin
               cnt <= cnt + 3'd1;
               if (cnt == 3'd4) begin
                  state <= S_SAT;
               end
            end
            S_SAT: begin
               out_ch    <= s_ch;
               out_data  <= s_ok ? mac_y_c : '0;
               out_sat   <= s_ok && mac_sat_c;
               out_valid <= 1'b1;
               state     <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_biquad_mc.sv
// Self-checking bench for biquad_mc against a transaction-level filter model.
module tb_biquad_mc;

   localparam int DW  = 16;
   localparam int CW  = 16;
   localparam int CF  = 14;
   localparam int NCH = 4;
   localparam int CHW = 2;

   logic                 clk = 1'b0;
   logic                 nreset = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [CHW-1:0]       in_ch = '0;
   logic signed [DW-1:0] in_data = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic [CHW-1:0]       out_ch;
   logic signed [DW-1:0] out_data;
   logic                 out_sat;
   logic                 coef_we = 1'b0;
   logic [CHW-1:0]       coef_ch = '0;
   logic [2:0]           coef_sel = '0;
   logic [CW-1:0]        coef_wdata = '0;
   logic [CW-1:0]        coef_rdata;
   logic                 clr = 1'b0;
   logic [CHW-1:0]       clr_ch = '0;

   biquad_mc dut (
      .clk        (clk),
      .nreset     (nreset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ch      (in_ch),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ch     (out_ch),
      .out_data   (out_data),
      .out_sat    (out_sat),
      .coef_we    (coef_we),
      .coef_ch    (coef_ch),
      .coef_sel   (coef_sel),
      .coef_wdata (coef_wdata),
      .coef_rdata (coef_rdata),
      .clr        (clr),
      .clr_ch     (clr_ch)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   // Model state: coefficient banks indexed a1,a2,b0,b1,b2 and history
   int mc [NCH][5];
   int mx1 [NCH];
   int mx2 [NCH];
   int my1 [NCH];
   int my2 [NCH];

   typedef struct {
      int ch;
      int y;
      int sat;
   } exp_t;
   exp_t exp_q [$];
   int   hs_q [$];

   int last_y = 0;
   int last_sat = 0;
   bit bp_rand = 1'b0;
   bit hold_ready = 1'b1;

   task automatic chk(input string nm, input longint act, input longint req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic chk_fail(input string nm);
      vectors++;
      miscompares++;
      $display("FAIL %s: condition not met (t=%0t)", nm, $time);
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         for (int k = 0; k < 5; k++) mc[c][k] = 0;
         mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
      end
   endtask

   // Sink readiness changes just after the active edge
   always begin
      @(posedge clk);
      #2;
      out_ready = bp_rand ? 1'($urandom_range(0, 1)) : hold_ready;
   end

   // Output compare process
   bit pv = 1'b0;
   bit pr = 1'b0;
   int pd = 0;
   int ps = 0;
   int pc = 0;
   always @(negedge clk) begin
      if (!nreset) begin
         pv = 1'b0;
      end else begin
         if (out_valid) begin
            chk("in_ready_while_busy", in_ready, 0);
            if (!pv) begin
               if (hs_q.size() == 0) chk_fail("out_valid_without_pending_handshake");
               else chk("latency", cyc - hs_q.pop_front(), 7);
            end else if (!pr) begin
               chk("hold_data", int'(out_data), pd);
               chk("hold_sat", out_sat, ps);
               chk("hold_ch", out_ch, pc);
            end
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  chk_fail("spurious_output");
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("out_data", int'(out_data), e.y);
                  chk("out_sat", out_sat, e.sat);
                  chk("out_ch", out_ch, e.ch);
                  last_y   = int'(out_data);
                  last_sat = int'(out_sat);
               end
            end
         end
         pv = out_valid;
         pr = out_ready;
         pd = int'(out_data);
         ps = int'(out_sat);
         pc = int'(out_ch);
      end
   end

   task automatic send(input int ch, input int x, output int ey, output int es);
      int n;
      longint acc;
      longint r;
      n  = 0;
      ey = 0;
      es = 0;
      @(negedge clk);
      while (!in_ready) begin
         if (n >= 100) begin
            chk_fail("in_ready_timeout");
            return;
         end
         @(negedge clk);
         n++;
      end
      in_valid = 1'b1;
      in_ch    = CHW'(ch);
      in_data  = DW'(x);
      hs_q.push_back(cyc);
      // y = b0*x + b1*x1 + b2*x2 + a1*y1 + a2*y2, rounded half-up, clamped
      acc = longint'(mc[ch][2]) * x + longint'(mc[ch][3]) * mx1[ch]
          + longint'(mc[ch][4]) * mx2[ch] + longint'(mc[ch][0]) * my1[ch]
          + longint'(mc[ch][1]) * my2[ch];
      r = (acc + longint'(1 << (CF - 1))) >>> CF;
      if (r > 32767) begin
         ey = 32767; es = 1;
      end else if (r < -32768) begin
         ey = -32768; es = 1;
      end else begin
         ey = int'(r);
      end
      mx2[ch] = mx1[ch]; mx1[ch] = x;
      my2[ch] = my1[ch]; my1[ch] = ey;
      exp_q.push_back('{ch: ch, y: ey, sat: es});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_q.size() != 0) begin
         @(negedge clk);
         n++;
         if (n > 300) begin
            chk_fail("output_drain_timeout");
            exp_q.delete();
            hs_q.delete();
            return;
         end
      end
   endtask

   task automatic wr_coef(input int ch, input int sel, input logic [15:0] val);
      @(negedge clk);
      coef_we    = 1'b1;
      coef_ch    = CHW'(ch);
      coef_sel   = 3'(sel);
      coef_wdata = val;
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      if (ch < NCH && sel < 5) mc[ch][sel] = int'($signed(val));
   endtask

   task automatic rd_coef(input string nm, input int ch, input int sel, input int req);
      @(negedge clk);
      coef_ch  = CHW'(ch);
      coef_sel = 3'(sel);
      #1;
      chk(nm, coef_rdata, req);
   endtask

   task automatic clr_hist(input int ch);
      @(negedge clk);
      clr    = 1'b1;
      clr_ch = CHW'(ch);
      @(posedge clk);
      #1;
      clr = 1'b0;
      mx1[ch] = 0; mx2[ch] = 0; my1[ch] = 0; my2[ch] = 0;
   endtask

   task automatic run1(input string nm, input int ch, input int x, input int ly, input int ls);
      int ey, es;
      send(ch, x, ey, es);
      chk({nm, "_model"}, ey, ly);
      chk({nm, "_model_sat"}, es, ls);
      wait_done();
      chk({nm, "_dut"}, last_y, ly);
      chk({nm, "_dut_sat"}, last_sat, ls);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ey, es, n;
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_sat", out_sat, 0);
      nreset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_release_in_ready", in_ready, 1);

      // Passthrough on ch0
      wr_coef(0, 2, 16'h4000);
      run1("pass", 0, 1000, 1000, 0);

      // Recursion on ch1
      wr_coef(1, 2, 16'h4000);
      wr_coef(1, 0, 16'h2000);
      run1("rec0", 1, 16384, 16384, 0);
      run1("rec1", 1, 0, 8192, 0);
      run1("rec2", 1, 0, 4096, 0);

      // Saturation and rounding on ch3
      wr_coef(3, 2, 16'h7FFF);
      run1("sat_pos", 3, 30000, 32767, 1);
      run1("sat_neg", 3, -30000, -32768, 1);
      wr_coef(3, 2, 16'h2000);
      run1("rnd_pos", 3, 3, 2, 0);
      run1("rnd_neg", 3, -3, -1, 0);

      // Channel independence and clear
      clr_hist(0);
      wr_coef(0, 0, 16'h2000);
      wr_coef(2, 0, 16'h2000);
      run1("ind_c0a", 0, 16384, 16384, 0);
      run1("ind_c2a", 2, 0, 0, 0);
      run1("ind_c0b", 0, 0, 8192, 0);
      run1("ind_c2b", 2, 0, 0, 0);
      run1("ind_c0c", 0, 0, 4096, 0);
      clr_hist(0);
      run1("clr_c0", 0, 0, 0, 0);

      // Backpressure
      hold_ready = 1'b0;
      send(3, 100, ey, es);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_out_valid_seen", out_valid, 1);
      repeat (10) @(negedge clk);
      chk("bp_still_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      hold_ready = 1'b1;
      wait_done();
      chk("bp_data", last_y, 50);

      // Coefficient write while a sample is in flight
      send(3, 1000, ey, es);
      wr_coef(3, 2, 16'h4000);
      chk("midwr_model", ey, 500);
      wait_done();
      chk("midwr_old_b0", last_y, 500);
      run1("midwr_new_b0", 3, 1000, 1000, 0);

      // Reserved and valid readback
      wr_coef(0, 5, 16'h1234);
      rd_coef("rd_reserved", 0, 5, 0);
      rd_coef("rd_reserved7", 0, 7, 0);
      rd_coef("rd_c0_b0", 0, 2, 16'h4000);
      rd_coef("rd_c1_a1", 1, 0, 16'h2000);

      // Randomized traffic with backpressure, writes and clears
      bp_rand = 1'b1;
      repeat (150) begin
         send($urandom_range(0, 3), int'($urandom_range(0, 65535)) - 32768, ey, es);
         if ($urandom_range(0, 2) == 0)
            wr_coef($urandom_range(0, 3), $urandom_range(0, 7), 16'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            wait_done();
            if ($urandom_range(0, 1) == 1) clr_hist($urandom_range(0, 3));
         end
      end
      wait_done();
      bp_rand = 1'b0;
      hold_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset in the middle of a computation
      wr_coef(1, 2, 16'h4000);
      send(1, 5000, ey, es);
      @(negedge clk);
      @(negedge clk);
      nreset = 1'b0;
      exp_q.delete();
      hs_q.delete();
      model_reset();
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      for (int c = 0; c < NCH; c++)
         for (int k = 0; k < 5; k++)
            rd_coef("midrst_coef_zero", c, k, 0);
      @(negedge clk);
      nreset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_in_ready_release", in_ready, 1);
      repeat (12) @(negedge clk);
      chk("midrst_no_output", out_valid, 0);
      wr_coef(1, 0, 16'h4000);
      wr_coef(1, 3, 16'h4000);
      run1("midrst_hist_zero", 1, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
